// File: rtl/register_readback_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : register_readback_serializer
//  Description : Snapshots a parallel register value on request and shifts it
//                out one bit at a time over a valid/ready serial handshake,
//                MSB- or LSB-first, qualified by Tick & ClockEnable.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_readback_serializer #(
  parameter int NrOfBits = 8,
  parameter bit MsbFirst = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                ClockEnable,
  input  logic [NrOfBits-1:0] D,
  input  logic                Start,
  input  logic                Abort,
  input  logic                SerReady,
  output logic                SerOut,
  output logic                SerValid,
  output logic                Busy,
  output logic                Done
);

  localparam int                 c_CNT_W = (NrOfBits > 2) ? $clog2(NrOfBits) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NrOfBits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NrOfBits-1:0]   r_shift;
  logic [NrOfBits-1:0]   w_shift_nxt;
  logic [NrOfBits-1:0]   w_shifted;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic                  w_active;
  logic                  w_out_bit;

  assign w_active = Tick & ClockEnable;

  // Output end of the shift register and the zero-filled value after one transfer
  generate
    if (MsbFirst) begin : g_msb_first
      assign w_out_bit = r_shift[NrOfBits-1];
      assign w_shifted = {r_shift[NrOfBits-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit = r_shift[0];
      assign w_shifted = {1'b0, r_shift[NrOfBits-1:1]};
    end
  endgenerate

  // Next-state, datapath update and Moore outputs; nothing moves unless the cycle is active
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    SerOut      = 1'b0;
    SerValid    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active && Start) begin
          w_shift_nxt = D;
          w_count_nxt = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        Busy     = 1'b1;
        SerValid = 1'b1;
        SerOut   = w_out_bit;
        if (w_active) begin
          // Abort wins over a simultaneous transfer, even the last one
          if (Abort) begin
            w_state_nxt = IDLE;
          end else if (SerReady) begin
            w_shift_nxt = w_shifted;
            // The final bit ends the readback; the counter is held rather than wrapped
            if (r_count == c_LAST) begin
              w_state_nxt = DONE;
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end
      end
      DONE: begin
        Done = 1'b1;
        if (w_active) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset ignores the tick qualifier
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire
